// File: rtl/fifo_rd_ctrl.sv
// fifo_rd_ctrl: read-side controller for the asynchronous FIFO.
// Runs in the read clock domain. It pops words without ever reading an empty
// FIFO, absorbs the one-cycle FIFO read latency in a 3-entry circular buffer,
// and presents the words downstream on a valid/ready stream.
//
// Ports:
//   rdClk     read-domain clock, all logic on its rising edge
//   rst       synchronous active-high reset
//   en        drain enable (0 = issue no new reads; in-flight reads still land)
//   fifoEmpty FIFO empty flag, rdClk domain
//   dout      FIFO read data, valid in the cycle after an rdEn cycle
//   rdEn      FIFO pop strobe
//   outData   stream data (head of buffer)
//   outValid  stream valid
//   outReady  stream ready from the consumer
//   rdCount   words popped from the FIFO since reset (wraps)
module fifo_rd_ctrl #(
  parameter int DATA_W = 8,
  parameter int CNT_W  = 16
) (
  input  logic              rdClk,
  input  logic              rst,
  input  logic              en,
  input  logic              fifoEmpty,
  input  logic [DATA_W-1:0] dout,
  output logic              rdEn,
  output logic [DATA_W-1:0] outData,
  output logic              outValid,
  input  logic              outReady,
  output logic [CNT_W-1:0]  rdCount
);

  logic [1:0]        occ;
  logic [1:0]        head;
  logic [1:0]        tail;
  logic              inflight;
  logic [DATA_W-1:0] mem [3];
  logic [CNT_W-1:0]  cnt;

  logic       pop;
  logic [2:0] pending;
  logic [1:0] occNext;

  function automatic logic [1:0] nextPtr(input logic [1:0] p);
    return (p == 2'd2) ? 2'd0 : p + 2'd1;
  endfunction

  // Reads are reserved against buffer space counting the word still in
  // flight, so a full buffer plus latency can never be over-popped.
  // outReady deliberately plays no part here.
  always_comb begin
    pending  = {1'b0, occ} + {2'b00, inflight};
    rdEn     = en && !fifoEmpty && (pending < 3'd3) && !rst;
    outValid = (occ != 2'd0);
    outData  = mem[head];
    pop      = outValid && outReady;
    occNext  = occ + {1'b0, inflight} - {1'b0, pop};
  end

  assign rdCount = cnt;

  always_ff @(posedge rdClk) begin
    if (rst) begin
      occ      <= '0;
      head     <= '0;
      tail     <= '0;
      inflight <= 1'b0;
      cnt      <= '0;
      for (int unsigned i = 0; i < 3; i++) begin
        mem[i] <= '0;
      end
    end else begin
      inflight <= rdEn;
      if (rdEn) begin
        cnt <= cnt + 1'b1;
      end
      if (inflight) begin
        mem[tail] <= dout;
        tail      <= nextPtr(tail);
      end
      if (pop) begin
        head <= nextPtr(head);
      end
      occ <= occNext;
    end
  end

endmodule
